sync_arith_unit_pipe: RTL and testbench

//  Pipelined, width-parametrised successor of the 4-op synchronous arithmetic unit.

---
 rtl/sync_arith_pkg.sv | 31 +++
 rtl/sync_arith_flags.sv | 23 ++
 rtl/sync_arith_unit_pipe.sv | 183 ++++++++++++++++++
 tb/tb_sync_arith_unit_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sync_arith_pkg.sv
// -----------------------------------------------------------------------------
// sync_arith_pkg
//   Shared definitions for the pipelined synchronous arithmetic unit:
//   opcode enumeration, status-bit indices and the shift-amount range check.
// -----------------------------------------------------------------------------
package sync_arith_pkg;

  typedef enum logic [2:0] {
    OP_CONV = 3'b000,  // two's complement -> sign-magnitude
    OP_CMP  = 3'b001,  // signed A > B
    OP_SET  = 3'b010,  // set bit B of A
    OP_SHL  = 3'b011,  // logical shift left A by B
    OP_ADD  = 3'b100,  // A + B with overflow
    OP_SUB  = 3'b101   // A - B with overflow
  } op_t;

  // Bit positions inside the 4-bit status word.
  localparam int ST_ERR  = 3;
  localparam int ST_ODD  = 2;
  localparam int ST_ZERO = 1;
  localparam int ST_OVF  = 0;

  // True when a signed bit index/shift amount addresses a bit of a
  // bits-wide word. The amount arrives sign-extended to 64 bits, which
  // covers every operand width up to 64.
  function automatic logic shamt_ok(input logic signed [63:0] amt,
                                    input int unsigned        bits);
    return (amt >= 0) && (amt < longint'(bits));
  endfunction

endpackage

// File: rtl/sync_arith_flags.sv
// -----------------------------------------------------------------------------
// sync_arith_flags
//   Combinational result flags for the output stage.
//   Ports:
//     value      in  BITS  result word
//     zeros      out 1     value is all zeros
//     odd_zeros  out 1     number of 0 bits in value is odd
// -----------------------------------------------------------------------------
module sync_arith_flags #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] value,
  output logic            zeros,
  output logic            odd_zeros
);

  assign zeros = (value == '0);

  // Parity of the inverted word is the parity of the zero-bit count,
  // independent of whether BITS is even or odd.
  assign odd_zeros = ^(~value);

endmodule

// File: rtl/sync_arith_unit_pipe.sv
// -----------------------------------------------------------------------------
// sync_arith_unit_pipe
//   Two-stage pipelined signed arithmetic unit with valid/ready handshake on
//   both sides, overflow detection for ADD/SUB, illegal-op / range errors and
//   a saturating error counter.
//   Stage 1 registers the op result plus error/overflow; stage 2 registers the
//   result with the full status word and drives the outputs.
//   Ports:
//     i_clk      in   1         clock, rising edge
//     i_reset    in   1         synchronous active-high reset
//     i_arg_A    in   BITS      operand A, signed
//     i_arg_B    in   BITS      operand B, signed
//     i_op       in   3         opcode (op_t); 110/111 are illegal
//     i_valid    in   1         operands/op valid
//     o_ready    out  1         unit accepts this cycle
//     o_result   out  BITS      result, signed
//     o_status   out  4         {ERROR, ODD_ZEROS, ZEROS, OVERFLOW}
//     o_valid    out  1         o_result/o_status valid
//     i_ready    in   1         downstream accepts result
//     o_err_cnt  out  CNT_BITS  saturating count of ERROR results
// -----------------------------------------------------------------------------
module sync_arith_unit_pipe
  import sync_arith_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic signed [BITS-1:0] i_arg_A,
  input  logic signed [BITS-1:0] i_arg_B,
  input  logic [2:0]             i_op,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [BITS-1:0]        o_result,
  output logic [3:0]             o_status,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CNT_BITS-1:0]    o_err_cnt
);

  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] ONE     = BITS'(1);

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  // Depends only on pipeline state and i_ready, never on i_valid.
  assign o_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage-1 datapath (combinational)
  // ---------------------------------------------------------------------------
  op_t             op;
  logic            shamt_valid;
  logic [BITS-1:0] neg_a;
  logic [BITS-1:0] sum;
  logic [BITS-1:0] diff;
  logic [BITS-1:0] op_res;
  logic            op_err;
  logic            op_ovf;

  assign op          = op_t'(i_op);
  assign shamt_valid = shamt_ok(64'(i_arg_B), BITS);
  assign neg_a       = -i_arg_A;
  assign sum         = i_arg_A + i_arg_B;
  assign diff        = i_arg_A - i_arg_B;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    op_res = '0;
    op_err = 1'b0;
    op_ovf = 1'b0;
    case (op)
      OP_CONV: begin
        if (i_arg_A == MIN_NEG)   op_err = 1'b1;  // no positive counterpart
        else if (i_arg_A[BITS-1]) op_res = {1'b1, neg_a[BITS-2:0]};
        else                      op_res = i_arg_A;
      end
      OP_CMP:  op_res = (i_arg_A > i_arg_B) ? ONE : '0;
      OP_SET: begin
        if (!shamt_valid) op_err = 1'b1;
        else              op_res = i_arg_A | (ONE << i_arg_B);
      end
      OP_SHL: begin
        if (!shamt_valid) op_err = 1'b1;
        else              op_res = i_arg_A << i_arg_B;
      end
      OP_ADD: begin
        op_res = sum;
        op_ovf = (i_arg_A[BITS-1] == i_arg_B[BITS-1]) &&
                 (sum[BITS-1] != i_arg_A[BITS-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (i_arg_A[BITS-1] != i_arg_B[BITS-1]) &&
                 (diff[BITS-1] != i_arg_A[BITS-1]);
      end
      default: op_err = 1'b1;  // 110 / 111
    endcase
    if (op_err) begin
      op_res = '0;
      op_ovf = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] s1_result;
  logic            s1_err;
  logic            s1_ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while
  // the matching valid bit is set, which is reset.
  always_ff @(posedge i_clk) begin
    if (s1_adv && i_valid) begin
      s1_result <= op_res;
      s1_err    <= op_err;
      s1_ovf    <= op_ovf;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: flags, status and outputs
  // ---------------------------------------------------------------------------
  logic       flag_zero;
  logic       flag_odd;
  logic [3:0] s1_status;

  sync_arith_flags #(.BITS(BITS)) u_flags (
    .value     (s1_result),
    .zeros     (flag_zero),
    .odd_zeros (flag_odd)
  );

  always_comb begin
    s1_status = '0;
    if (s1_err) begin
      s1_status[ST_ERR] = 1'b1;
    end else begin
      s1_status[ST_ODD]  = flag_odd;
      s1_status[ST_ZERO] = flag_zero;
      s1_status[ST_OVF]  = s1_ovf;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_status  <= '0;
      o_err_cnt <= '0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= s1_result;
        o_status <= s1_status;
        if (s1_err && (o_err_cnt != '1)) begin
          o_err_cnt <= o_err_cnt + CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_arith_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_sync_arith_unit_pipe
//   Directed self-checking bench for sync_arith_unit_pipe (BITS=32,
//   CNT_BITS=2 so counter saturation is reachable in a few ops).
// -----------------------------------------------------------------------------
module tb_sync_arith_unit_pipe;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_arg_A;
  logic [31:0] i_arg_B;
  logic [2:0]  i_op;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_result;
  logic [3:0]  o_status;
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_err_cnt;

  int vectors     = 0;
  int miscompares = 0;

  sync_arith_unit_pipe #(.BITS(32), .CNT_BITS(2)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_arg_A   (i_arg_A),
    .i_arg_B   (i_arg_B),
    .i_op      (i_op),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_result  (o_result),
    .o_status  (o_status),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_err_cnt (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One op through an otherwise idle pipeline with i_ready held high.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_st,
                        input logic [1:0] exp_cnt);
    i_op = op; i_arg_A = a; i_arg_B = b; i_ready = 1'b1; i_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    chk({tag, "_lat1"}, o_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, o_valid, 1'b1);
    chk({tag, "_result"}, o_result, exp_res);
    chk({tag, "_status"}, o_status, exp_st);
    chk({tag, "_errcnt"}, o_err_cnt, exp_cnt);
    tick();
  endtask

  logic [31:0] bp_a   [6] = '{32'd3, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd100};
  logic [31:0] bp_b   [6] = '{32'd2, 32'd0, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFC, 32'hFFFF_FF9C};
  logic [31:0] bp_exp [6] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
  int in_idx;
  int out_idx;

  initial begin
    // ---- 1: reset with a valid op presented -------------------------------
    i_reset = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    i_op = 3'b100; i_arg_A = 32'd1; i_arg_B = 32'd1;
    tick();
    tick();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_status", o_status, 4'b0000);
    chk("rst_errcnt", o_err_cnt, 2'd0);
    i_reset = 1'b0; i_valid = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1'b1);
    tick();
    chk("rst_no_op", o_valid, 1'b0);

    // ---- 2: ADD / SUB -----------------------------------------------------
    // 0x8000_0000 has 31 zero bits, so ODD_ZEROS is set with OVERFLOW.
    run_op("add_ovf", 3'b100, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101, 2'd0);
    run_op("add_zero", 3'b100, 32'd5, 32'hFFFF_FFFB, 32'd0, 4'b0010, 2'd0);
    run_op("sub_ovf", 3'b101, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0101, 2'd0);

    // ---- 3: SET / SHL range -----------------------------------------------
    run_op("set_b3", 3'b010, 32'd0, 32'd3, 32'd8, 4'b0100, 2'd0);
    run_op("shl_b32", 3'b011, 32'd1, 32'd32, 32'd0, 4'b1000, 2'd1);
    run_op("shl_b4", 3'b011, 32'd3, 32'd4, 32'h30, 4'b0000, 2'd1);

    // ---- 4: CONV and illegal op -------------------------------------------
    run_op("conv_m1", 3'b000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0001, 4'b0000, 2'd1);
    run_op("conv_pos", 3'b000, 32'd5, 32'd0, 32'd5, 4'b0000, 2'd1);
    run_op("conv_min", 3'b000, 32'h8000_0000, 32'd0, 32'd0, 4'b1000, 2'd2);
    run_op("op_111", 3'b111, 32'd7, 32'd7, 32'd0, 4'b1000, 2'd3);
    run_op("set_bneg", 3'b010, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1000, 2'd3);

    // ---- 5: backpressure stream of 6 CMP ops ------------------------------
    in_idx = 0; out_idx = 0;
    i_op = 3'b001;
    for (int c = 0; c < 40 && out_idx < 6; c++) begin
      i_ready = !(c >= 3 && c <= 5);
      i_valid = (in_idx < 6);
      i_arg_A = bp_a[in_idx % 6];
      i_arg_B = bp_b[in_idx % 6];
      #1;
      if (c == 4 || c == 5) chk($sformatf("bp_ready_low_c%0d", c), o_ready, 1'b0);
      if (!i_ready) begin
        chk($sformatf("bp_hold_valid_c%0d", c), o_valid, 1'b1);
        chk($sformatf("bp_hold_result_c%0d", c), o_result, bp_exp[out_idx]);
      end
      if (o_valid && i_ready) begin
        chk($sformatf("bp_result_%0d", out_idx), o_result, bp_exp[out_idx]);
        chk($sformatf("bp_status_%0d", out_idx), o_status,
            (bp_exp[out_idx] == 32'd1) ? 4'b0100 : 4'b0010);
        out_idx++;
      end
      if (i_valid && o_ready) in_idx++;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("bp_out_count", 64'(out_idx), 64'd6);
    tick();
    chk("bp_no_dup", o_valid, 1'b0);

    // ---- 6: saturation from a fresh counter, then mid-stream reset ---------
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("sat_cleared", o_err_cnt, 2'd0);
    run_op("sat_1", 3'b110, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd1);
    run_op("sat_2", 3'b111, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd2);
    run_op("sat_3", 3'b110, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd3);
    run_op("sat_4", 3'b111, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd3);
    run_op("sat_5", 3'b110, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd3);

    i_op = 3'b100; i_arg_A = 32'd2; i_arg_B = 32'd3; i_valid = 1'b1;
    tick();                      // op accepted into stage 1
    i_reset = 1'b1;
    tick();                      // reset flushes the in-flight op
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_errcnt", o_err_cnt, 2'd0);
    i_reset = 1'b0; i_valid = 1'b0;
    tick();
    chk("midrst_flushed", o_valid, 1'b0);
    tick();
    chk("midrst_flushed2", o_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
